// File: rtl/edge_event_scheduler.sv
// Round-robin scheduler that funnels per-source event counts through one
// edge/ack crossing channel, one edge in flight at a time.
module edge_event_scheduler #(
  parameter int  NumSrc     = 4,
  parameter int  CntWidth   = 3,
  parameter int  AckTimeout = 256,
  localparam int IdW        = $clog2(NumSrc)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [NumSrc-1:0] event_i,
  input  logic              ack_i,
  input  logic              clr_i,
  output logic              edge_o,
  output logic [IdW-1:0]    src_id_o,
  output logic              busy_o,
  output logic [NumSrc-1:0] pending_o,
  output logic [NumSrc-1:0] overflow_o,
  output logic              timeout_o
);

  localparam int              TmrW    = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(AckTimeout - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q [NumSrc];
  logic [CntWidth-1:0] cnt_d [NumSrc];
  logic [NumSrc-1:0]   nonzero;
  logic [NumSrc-1:0]   dec_vec;
  logic [NumSrc-1:0]   ovf_set;
  logic [2*NumSrc-1:0] nz_rot;
  logic [IdW-1:0]      rr_ptr_q;
  logic [IdW-1:0]      src_id_q;
  logic [IdW-1:0]      winner;
  logic                any_pending;
  logic                grant;
  logic                tmo_hit;
  logic [TmrW-1:0]     timer_q;

  // Saturating up/down step; MSB of the result flags a dropped increment.
  function automatic logic [CntWidth:0] sat_step(input logic [CntWidth-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
    logic [CntWidth:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (&c) r = {1'b1, c};
      else    r = {1'b0, c + CntWidth'(1)};
    end else if (dec && !inc) begin
      r = {1'b0, c - CntWidth'(1)};
    end
    return r;
  endfunction

  function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base,
                                              input logic [IdW:0]   off);
    logic [IdW:0] s;
    s = {1'b0, base} + off;
    if (s >= (IdW+1)'(NumSrc)) s = s - (IdW+1)'(NumSrc);
    return s[IdW-1:0];
  endfunction

  // Arbitration: rotate the nonzero map so bit 0 is the rr pointer.
  always_comb begin
    nonzero = '0;
    for (int k = 0; k < NumSrc; k++) nonzero[k] = (cnt_q[k] != '0);
  end

  assign nz_rot      = {nonzero, nonzero} >> rr_ptr_q;
  assign any_pending = |nonzero;
  assign grant       = (state_q == IDLE) && enable_i && any_pending;

  always_comb begin
    winner = rr_ptr_q;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (nz_rot[i]) winner = wrap_add(rr_ptr_q, (IdW+1)'(i));
    end
  end

  // Counter update: increment from events, decrement on the SEND cycle.
  always_comb begin
    dec_vec = '0;
    ovf_set = '0;
    for (int k = 0; k < NumSrc; k++) begin
      dec_vec[k] = (state_q == SEND) && (src_id_q == IdW'(k));
      {ovf_set[k], cnt_d[k]} = sat_step(cnt_q[k], event_i[k], dec_vec[k]);
    end
  end

  if (AckTimeout != 0) begin : g_tmo
    assign tmo_hit = (state_q == WAIT_ACK) && !ack_i && (timer_q == TmrLast);
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (grant) state_d = SEND;
      SEND:     state_d = WAIT_ACK;
      WAIT_ACK: if (ack_i || tmo_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    edge_o = 1'b0;
    busy_o = 1'b0;
    unique case (state_q)
      SEND: begin
        edge_o = 1'b1;
        busy_o = 1'b1;
      end
      WAIT_ACK: busy_o = 1'b1;
      default: ;
    endcase
  end

  // Registered counters, pointer, grant index, ack timer and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumSrc; k++) cnt_q[k] <= '0;
      rr_ptr_q   <= '0;
      src_id_q   <= '0;
      timer_q    <= '0;
      overflow_o <= '0;
      timeout_o  <= 1'b0;
    end else begin
      for (int k = 0; k < NumSrc; k++) cnt_q[k] <= cnt_d[k];
      if (grant)            src_id_q <= winner;
      if (state_q == SEND)  rr_ptr_q <= wrap_add(src_id_q, (IdW+1)'(1));
      timer_q    <= (state_q == WAIT_ACK) ? timer_q + TmrW'(1) : '0;
      overflow_o <= (overflow_o & ~{NumSrc{clr_i}}) | ovf_set;
      timeout_o  <= (timeout_o & ~clr_i) | tmo_hit;
    end
  end

  assign src_id_o  = src_id_q;
  assign pending_o = nonzero;

  a_no_back_to_back: assert property (@(posedge clk_i) disable iff (!rst_ni)
    edge_o |=> !edge_o);

  a_edge_has_event: assert property (@(posedge clk_i) disable iff (!rst_ni)
    edge_o |-> (cnt_q[src_id_q] != '0));

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: directed scenarios plus randomized traffic
// against a timestamp-based reference model.
module tb_edge_event_scheduler;

  localparam int NS   = 4;
  localparam int CW   = 3;
  localparam int TMO  = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int INF  = 1 << 30;

  logic          clk;
  logic          rst_ni;
  logic          enable_i;
  logic [NS-1:0] event_i;
  logic          ack_i;
  logic          clr_i;
  logic          edge_o;
  logic [1:0]    src_id_o;
  logic          busy_o;
  logic [NS-1:0] pending_o;
  logic [NS-1:0] overflow_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  edge_event_scheduler #(
    .NumSrc(NS),
    .CntWidth(CW),
    .AckTimeout(TMO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .enable_i(enable_i),
    .event_i(event_i),
    .ack_i(ack_i),
    .edge_o(edge_o),
    .src_id_o(src_id_o),
    .busy_o(busy_o),
    .pending_o(pending_o),
    .overflow_o(overflow_o),
    .timeout_o(timeout_o),
    .clr_i(clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts plus the timestamps of the current edge and of
  // the cycle at which the channel is free to grant again.
  int            m_cnt [NS];
  int            m_rr;
  int            m_src;
  int            m_cyc;
  int            m_edge_at;
  int            m_free_at;
  logic [NS-1:0] m_ovf;
  logic          m_tmo;

  function automatic void model_reset();
    for (int k = 0; k < NS; k++) m_cnt[k] = 0;
    m_rr      = 0;
    m_src     = 0;
    m_cyc     = 0;
    m_edge_at = -10;
    m_free_at = 0;
    m_ovf     = '0;
    m_tmo     = 1'b0;
  endfunction

  function automatic void model_update(input logic [NS-1:0] ev, input logic en,
                                       input logic ack, input logic clr);
    int   dec_src;
    int   pick;
    logic tmo_set;
    dec_src = (m_cyc == m_edge_at) ? m_src : -1;
    pick    = -1;
    if (m_cyc >= m_free_at && en) begin
      for (int i = 0; i < NS; i++)
        if (pick < 0 && m_cnt[(m_rr + i) % NS] > 0) pick = (m_rr + i) % NS;
    end
    tmo_set = 1'b0;
    if (m_cyc > m_edge_at && m_free_at == INF) begin
      if (ack) m_free_at = m_cyc + 1;
      else if (m_cyc - m_edge_at == TMO) begin
        m_free_at = m_cyc + 1;
        tmo_set   = 1'b1;
      end
    end
    if (dec_src >= 0) m_rr = (dec_src + 1) % NS;
    if (pick >= 0) begin
      m_src     = pick;
      m_edge_at = m_cyc + 1;
      m_free_at = INF;
    end
    if (clr) m_ovf = '0;
    for (int k = 0; k < NS; k++) begin
      if (ev[k] && k != dec_src) begin
        if (m_cnt[k] == MAXC) m_ovf[k] = 1'b1;
        else m_cnt[k] = m_cnt[k] + 1;
      end else if (!ev[k] && k == dec_src) begin
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
    m_tmo = (clr ? 1'b0 : m_tmo) | tmo_set;
    m_cyc = m_cyc + 1;
  endfunction

  function automatic logic m_edge();
    return m_cyc == m_edge_at;
  endfunction

  function automatic logic m_busy();
    return (m_cyc >= m_edge_at) && (m_cyc < m_free_at);
  endfunction

  function automatic logic [NS-1:0] m_pend();
    logic [NS-1:0] p;
    for (int k = 0; k < NS; k++) p[k] = (m_cnt[k] != 0);
    return p;
  endfunction

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic step(input logic [NS-1:0] ev, input logic en,
                      input logic ack, input logic clr);
    event_i  = ev;
    enable_i = en;
    ack_i    = ack;
    clr_i    = clr;
    @(posedge clk);
    model_update(ev, en, ack, clr);
    #1;
  endtask

  task automatic do_reset();
    event_i  = '0;
    enable_i = 1'b0;
    ack_i    = 1'b0;
    clr_i    = 1'b0;
    rst_ni   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    event_i  = '0;
    enable_i = 1'b0;
    ack_i    = 1'b0;
    clr_i    = 1'b0;
    rst_ni   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (edge_o !== 1'b0) begin errors++; $display("FAIL reset_edge got=%b exp=0", edge_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (src_id_o !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", src_id_o); end
    checks++; if (pending_o !== 4'b0) begin errors++; $display("FAIL reset_pend got=%b exp=0000", pending_o); end
    checks++; if (overflow_o !== 4'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0000", overflow_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_tmo got=%b exp=0", timeout_o); end
    rst_ni = 1'b1;
    model_reset();
    for (int j = 0; j < 3; j++) begin
      step('0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (edge_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL reset_quiet cyc=%0d edge=%b busy=%b exp=0/0", j, edge_o, busy_o);
      end
    end
  endtask

  task automatic test_single_event();
    logic          exp_edge, exp_busy;
    logic [NS-1:0] exp_pend;
    int            off;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      step((j == 0) ? 4'b0001 : 4'b0000, 1'b1, (j == 6), 1'b0);
      off      = j + 1;
      exp_edge = (off == 2);
      exp_busy = (off >= 2 && off <= 6);
      exp_pend = (off <= 2) ? 4'b0001 : 4'b0000;
      checks++; if (edge_o !== exp_edge) begin errors++; $display("FAIL single_edge t+%0d got=%b exp=%b", off, edge_o, exp_edge); end
      checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL single_busy t+%0d got=%b exp=%b", off, busy_o, exp_busy); end
      checks++; if (pending_o !== exp_pend) begin errors++; $display("FAIL single_pend t+%0d got=%b exp=%b", off, pending_o, exp_pend); end
      if (exp_busy) begin
        checks++; if (src_id_o !== 2'd0) begin errors++; $display("FAIL single_src t+%0d got=%0d exp=0", off, src_id_o); end
      end
    end
  endtask

  task automatic test_round_robin();
    int cur, last_edge, nedge;
    int e_cyc [NS];
    int e_src [NS];
    do_reset();
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    cur = 1; last_edge = -100; nedge = 0;
    for (int j = 0; j < 30; j++) begin
      step('0, 1'b1, (cur == last_edge + 3), 1'b0);
      cur++;
      if (edge_o === 1'b1) begin
        if (nedge < NS) begin
          e_cyc[nedge] = cur;
          e_src[nedge] = int'(src_id_o);
        end
        last_edge = cur;
        nedge++;
      end
    end
    checks++; if (nedge != NS) begin errors++; $display("FAIL rr_count got=%0d exp=%0d", nedge, NS); end
    for (int k = 0; k < NS && k < nedge; k++) begin
      checks++; if (e_src[k] != k) begin errors++; $display("FAIL rr_order edge%0d got=%0d exp=%0d", k, e_src[k], k); end
      if (k > 0) begin
        checks++;
        if (e_cyc[k] - e_cyc[k-1] != 5) begin
          errors++; $display("FAIL rr_spacing edge%0d got=%0d exp=5", k, e_cyc[k] - e_cyc[k-1]);
        end
      end
    end
    checks++; if (pending_o !== 4'b0) begin errors++; $display("FAIL rr_drained got=%b exp=0000", pending_o); end
  endtask

  task automatic test_saturation();
    int n, bad;
    logic [NS-1:0] exp_ovf;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      step(4'b0100, 1'b0, 1'b0, 1'b0);
      exp_ovf = (j >= 7) ? 4'b0100 : 4'b0000;
      checks++; if (overflow_o !== exp_ovf) begin errors++; $display("FAIL sat_ovf ev%0d got=%b exp=%b", j + 1, overflow_o, exp_ovf); end
    end
    checks++; if (pending_o !== 4'b0100) begin errors++; $display("FAIL sat_pend got=%b exp=0100", pending_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sat_disabled_busy got=%b exp=0", busy_o); end
    n = 0; bad = 0;
    for (int j = 0; j < 40; j++) begin
      step('0, 1'b1, 1'b1, 1'b0);
      if (edge_o === 1'b1) begin
        n++;
        if (src_id_o !== 2'd2) bad++;
      end
    end
    checks++; if (n != 7) begin errors++; $display("FAIL sat_edges got=%0d exp=7", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL sat_src wrong=%0d exp=0", bad); end
    checks++; if (overflow_o !== 4'b0100) begin errors++; $display("FAIL sat_sticky got=%b exp=0100", overflow_o); end
    step('0, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow_o !== 4'b0) begin errors++; $display("FAIL sat_clr got=%b exp=0000", overflow_o); end
    for (int j = 0; j < 7; j++) step(4'b0100, 1'b0, 1'b0, 1'b0);
    checks++; if (overflow_o !== 4'b0) begin errors++; $display("FAIL sat_full_no_ovf got=%b exp=0000", overflow_o); end
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow_o !== 4'b0100) begin errors++; $display("FAIL sat_set_wins got=%b exp=0100", overflow_o); end
    step('0, 1'b0, 1'b0, 1'b1);
    checks++; if (overflow_o !== 4'b0) begin errors++; $display("FAIL sat_clr2 got=%b exp=0000", overflow_o); end
  endtask

  task automatic test_inc_dec();
    int   last_edge, n;
    logic prev_edge;
    do_reset();
    last_edge = -1; n = 0; prev_edge = 1'b0;
    for (int j = 0; j < 60; j++) begin
      step(4'b0010, 1'b1, 1'b1, 1'b0);
      if (j >= 1) begin
        checks++; if (pending_o !== 4'b0010) begin errors++; $display("FAIL incdec_pend cyc=%0d got=%b exp=0010", j + 1, pending_o); end
      end
      checks++; if (prev_edge && edge_o) begin errors++; $display("FAIL incdec_b2b cyc=%0d got=1 exp=0", j + 1); end
      if (edge_o === 1'b1) begin
        checks++; if (src_id_o !== 2'd1) begin errors++; $display("FAIL incdec_src cyc=%0d got=%0d exp=1", j + 1, src_id_o); end
        if (last_edge >= 0) begin
          checks++; if (j + 1 - last_edge != 3) begin errors++; $display("FAIL incdec_spacing cyc=%0d got=%0d exp=3", j + 1, j + 1 - last_edge); end
        end
        last_edge = j + 1;
        n++;
      end
      prev_edge = edge_o;
    end
    checks++; if (n != 20) begin errors++; $display("FAIL incdec_edges got=%0d exp=20", n); end
    checks++; if (overflow_o !== 4'b0010) begin errors++; $display("FAIL incdec_ovf got=%b exp=0010", overflow_o); end
  endtask

  task automatic test_timeout();
    int   cur;
    logic exp_busy, exp_edge, exp_tmo;
    do_reset();
    step(4'b0001, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= 17; j++) begin
      step((j == 4) ? 4'b1000 : 4'b0000, 1'b1, (j == 14), (j == 16));
      cur      = j + 1;
      exp_busy = (cur >= 2 && cur <= 10) || (cur >= 12 && cur <= 14);
      exp_edge = (cur == 2) || (cur == 12);
      exp_tmo  = (cur >= 11 && cur <= 16);
      checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL tmo_busy cyc=%0d got=%b exp=%b", cur, busy_o, exp_busy); end
      checks++; if (edge_o !== exp_edge) begin errors++; $display("FAIL tmo_edge cyc=%0d got=%b exp=%b", cur, edge_o, exp_edge); end
      checks++; if (timeout_o !== exp_tmo) begin errors++; $display("FAIL tmo_flag cyc=%0d got=%b exp=%b", cur, timeout_o, exp_tmo); end
      if (cur == 12) begin
        checks++; if (src_id_o !== 2'd3) begin errors++; $display("FAIL tmo_next_src got=%0d exp=3", src_id_o); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int j = 0; j < 6; j++) step(4'b1000, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    checks++; if (busy_o !== 1'b1 || edge_o !== 1'b0) begin errors++; $display("FAIL rmid_pre busy=%b edge=%b exp=1/0", busy_o, edge_o); end
    checks++; if (pending_o !== 4'b1000) begin errors++; $display("FAIL rmid_pre_pend got=%b exp=1000", pending_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy_o); end
    checks++; if (pending_o !== 4'b0) begin errors++; $display("FAIL rmid_pend got=%b exp=0000", pending_o); end
    checks++; if (src_id_o !== 2'd0) begin errors++; $display("FAIL rmid_src got=%0d exp=0", src_id_o); end
    checks++; if (edge_o !== 1'b0) begin errors++; $display("FAIL rmid_edge got=%b exp=0", edge_o); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
    for (int j = 0; j < 15; j++) begin
      step('0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (edge_o !== 1'b0 || busy_o !== 1'b0 || pending_o !== 4'b0) begin
        errors++; $display("FAIL rmid_after cyc=%0d edge=%b busy=%b pend=%b exp=0/0/0000", j, edge_o, busy_o, pending_o);
      end
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] ev;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < NS; k++) ev[k] = ($urandom_range(0, 5) == 0);
      step(ev, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
      checks++; if (edge_o !== m_edge()) begin errors++; $display("FAIL rand_edge cyc=%0d got=%b exp=%b", m_cyc, edge_o, m_edge()); end
      checks++; if (busy_o !== m_busy()) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", m_cyc, busy_o, m_busy()); end
      checks++; if (int'(src_id_o) != m_src) begin errors++; $display("FAIL rand_src cyc=%0d got=%0d exp=%0d", m_cyc, src_id_o, m_src); end
      checks++; if (pending_o !== m_pend()) begin errors++; $display("FAIL rand_pend cyc=%0d got=%b exp=%b", m_cyc, pending_o, m_pend()); end
      checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", m_cyc, overflow_o, m_ovf); end
      checks++; if (timeout_o !== m_tmo) begin errors++; $display("FAIL rand_tmo cyc=%0d got=%b exp=%b", m_cyc, timeout_o, m_tmo); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni   = 1'b0;
    event_i  = '0;
    enable_i = 1'b0;
    ack_i    = 1'b0;
    clr_i    = 1'b0;
    model_reset();
    test_reset();
    test_single_event();
    test_round_robin();
    test_saturation();
    test_inc_dec();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Shares one edge_propagator_ack clock-domain-crossing channel among NumSrc event sources, all in the transmit clock domain.
- Counts pending events per source and picks one source at a time, round-robin.
- Issues a single-cycle edge toward the crossing plus the winning source index, then waits for the crossing's tx-side acknowledge before issuing the next edge.
- Sits between local event generators (timers, DMA done, GPIO) and the CDC channel feeding the remote domain.

Parameters:
- NumSrc, 4, number of event sources (2..16).
- CntWidth, 3, width of each per-source pending counter; saturates at 2^CntWidth-1.
- AckTimeout, 256, cycles to wait in WAIT_ACK before abandoning the edge; 0 disables the timeout.
- IdW, $clog2(NumSrc), width of src_id_o (derived, not overridable).

Ports:
- clk_i  in  1  transmit-domain clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  when low, no new grants; an edge already in flight completes.
- event_i  in  NumSrc  per-source event; each cycle high counts as one event.
- ack_i  in  1  tx-side acknowledge from the CDC channel (ack_tx_o).
- edge_o  out  1  one-cycle pulse to the CDC channel edge_i.
- src_id_o  out  IdW  index of the granted source; valid while busy_o=1.
- busy_o  out  1  high in SEND and WAIT_ACK.
- pending_o  out  NumSrc  per-source (counter != 0).
- overflow_o  out  NumSrc  sticky; set when an event hits a saturated counter.
- timeout_o  out  1  sticky; set on an ack timeout.
- clr_i  in  1  synchronous clear of overflow_o and timeout_o.

Behaviour:
- Reset values: all counters 0, FSM IDLE, RR pointer 0, edge_o=0, src_id_o=0, busy_o=0, pending_o=0, overflow_o=0, timeout_o=0.
- Counters:
  - event_i[k]=1 increments cnt[k].
  - The SEND cycle of source k decrements cnt[k].
  - Increment and decrement in the same cycle leave the count unchanged.
  - An increment at saturation is dropped and sets overflow_o[k] on the next edge.
  - If clr_i and a new overflow occur in the same cycle, the set wins.
- FSM IDLE:
  - If enable_i=1 and any cnt!=0, pick the first nonzero source at or after rr_ptr, cyclically.
  - Register the winner into src_id_o and go to SEND.
  - Decisions use registered counter values, so an event arriving in cycle t is first eligible in cycle t+1.
- FSM SEND, exactly one cycle:
  - edge_o=1, cnt[src]--.
  - rr_ptr <= src+1, wrapping at NumSrc.
  - Next state WAIT_ACK.
  - ack_i in this cycle is ignored.
- FSM WAIT_ACK:
  - edge_o=0; a timer counts from 0.
  - ack_i=1 returns to IDLE.
  - If AckTimeout!=0 and the timer reaches AckTimeout-1 without ack_i, set timeout_o and return to IDLE. The event stays consumed and is not retried.
- IDLE lasts at least one cycle between edges, so edges are spaced at least 3 cycles apart (SEND, >=1 WAIT_ACK, IDLE).
- Latency: idle block, event_i pulse at cycle t -> cnt=1 at t+1 -> SEND/edge_o at t+2.
- enable_i low affects IDLE only. Counters keep accumulating while disabled.
- src_id_o holds its last value when idle.
- Asynchronous reset mid-operation returns everything to reset values immediately; pending events are lost.
- Assertions:
  - edge_o never high in two consecutive cycles.
  - edge_o implies the granted counter was != 0.

Test Plan:
- Single event: event_i=4'b0001 for 1 cycle at t, ack_i at t+6 -> edge_o high only at t+2, src_id_o=0, busy_o from t+2 to t+6, IDLE at t+7, pending_o=0 from t+3.
- Round-robin: event_i=4'b1111 for 1 cycle, ack 3 cycles after each edge -> edges in src order 0,1,2,3, each spaced by 5 cycles.
- Saturation: 9 consecutive event_i[2] cycles while enable_i=0 -> cnt[2]=7 and overflow_o[2]=1. Then enable_i=1 -> exactly 7 edges with src_id_o=2. clr_i clears overflow_o.
- Simultaneous increment/decrement: event_i[1] held high continuously with immediate acks -> cnt[1] never underflows, edge_o never high back-to-back.
- Timeout: AckTimeout=8, one event, ack_i never asserted -> timeout_o=1 exactly 8 cycles after SEND, FSM back to IDLE, next pending event still served.
- Reset mid-WAIT_ACK with cnt[3]=5: rst_ni low -> all outputs 0 immediately; after release, no edge_o without new events.
